// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types for the hazard/forwarding controller.
//   fwd_sel_e  - EX operand source select (regfile / WB / MEM)
//   hz_state_e - load-use stall FSM states
//   *_slot_t   - shadow copies of the EX, MEM and WB pipeline stages
package pipeline_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              regwrite;
        logic              memread;
    } ex_slot_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } mem_slot_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } wb_slot_t;

endpackage

// File: rtl/fwd_select.sv
// fwd_select: forwarding source choice for one EX operand.
//   i_rs           EX-stage source register of this operand
//   i_mem_*        destination / RegWrite / MemRead of the MEM-stage producer
//   i_wb_*         destination / RegWrite of the WB-stage producer
//   o_sel          FWD_MEM, FWD_WB or FWD_RF
module fwd_select
    import pipeline_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_AW
) (
    input  logic [ADDR_WIDTH-1:0] i_rs,
    input  logic [ADDR_WIDTH-1:0] i_mem_rd,
    input  logic                  i_mem_regwrite,
    input  logic                  i_mem_memread,
    input  logic [ADDR_WIDTH-1:0] i_wb_rd,
    input  logic                  i_wb_regwrite,
    output fwd_sel_e              o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // A load in MEM has no data yet, so it is never a MEM-forward source.
    assign w_mem_hit = i_mem_regwrite && !i_mem_memread && i_mem_rd != '0 && i_mem_rd == i_rs;
    assign w_wb_hit  = i_wb_regwrite && i_wb_rd != '0 && i_wb_rd == i_rs;
    // The younger producer (MEM) wins over WB.
    assign o_sel     = w_mem_hit ? FWD_MEM : w_wb_hit ? FWD_WB : FWD_RF;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: load-use stall, redirect flush and EX forwarding control.
//   clk, rst                  pipeline clock, async active-high reset
//   id_*                      ID-stage fields as they enter ID/EX
//   ex_redirect               EX resolved a taken branch or jump
//   stall_if                  hold PC and IF/ID
//   flush_ifid / flush_idex   load a NOP into IF/ID / bubble into ID/EX
//   fwd_a / fwd_b             EX operand source: 00 regfile, 01 WB, 10 MEM
// ADDR_WIDTH must equal pipeline_pkg::REG_AW (shadow slot width).
// LOAD_STALL_CYCLES is legal in 1..7.
module hazard_forward_ctrl
    import pipeline_pkg::*;
#(
    parameter int ADDR_WIDTH        = REG_AW,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] id_rs1,
    input  logic [ADDR_WIDTH-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [ADDR_WIDTH-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  ex_redirect,
    output logic                  stall_if,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

    ex_slot_t  r_ex;
    mem_slot_t r_mem;
    wb_slot_t  r_wb;
    hz_state_e r_state;
    hz_state_e w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    ex_slot_t  w_id_slot;
    logic      w_hz;
    logic      w_stall;
    logic      w_flush_ifid;
    logic      w_flush_idex;
    fwd_sel_e  w_fwd_a;
    fwd_sel_e  w_fwd_b;

    assign w_hz = id_valid && r_ex.memread && r_ex.rd != '0 &&
                  ((id_uses_rs1 && id_rs1 == r_ex.rd) || (id_uses_rs2 && id_rs2 == r_ex.rd));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Redirect discards any pending stall; a hazard seen while stalling
    // does not reload the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (ex_redirect) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (r_state == STALL) begin
            w_cnt_nxt = r_cnt - 3'd1;
            if (r_cnt == 3'd1)
                w_state_nxt = IDLE;
        end else if (w_hz && LOAD_STALL_CYCLES > 1) begin
            w_state_nxt = STALL;
            w_cnt_nxt   = STALL_RELOAD;
        end
    end

    always_comb begin
        w_flush_ifid = ex_redirect;
        w_stall      = !ex_redirect && (r_state == STALL || w_hz);
        w_flush_idex = ex_redirect || w_stall;
    end

    // Unused or invalid register fields are recorded as x0 so they never match.
    always_comb begin
        w_id_slot = '0;
        if (id_valid && !w_flush_idex)
            w_id_slot = '{rd:       id_rd,
                          rs1:      id_uses_rs1 ? id_rs1 : '0,
                          rs2:      id_uses_rs2 ? id_rs2 : '0,
                          regwrite: id_regwrite,
                          memread:  id_memread};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_ex  <= w_id_slot;
            r_mem <= '{rd: r_ex.rd, regwrite: r_ex.regwrite, memread: r_ex.memread};
            r_wb  <= '{rd: r_mem.rd, regwrite: r_mem.regwrite};
        end
    end

    fwd_select #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_a (
        .i_rs           (r_ex.rs1),
        .i_mem_rd       (r_mem.rd),
        .i_mem_regwrite (r_mem.regwrite),
        .i_mem_memread  (r_mem.memread),
        .i_wb_rd        (r_wb.rd),
        .i_wb_regwrite  (r_wb.regwrite),
        .o_sel          (w_fwd_a)
    );

    fwd_select #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_b (
        .i_rs           (r_ex.rs2),
        .i_mem_rd       (r_mem.rd),
        .i_mem_regwrite (r_mem.regwrite),
        .i_mem_memread  (r_mem.memread),
        .i_wb_rd        (r_wb.rd),
        .i_wb_regwrite  (r_wb.regwrite),
        .o_sel          (w_fwd_b)
    );

    // Outputs are held low for the whole time reset is asserted.
    assign stall_if   = !rst && w_stall;
    assign flush_ifid = !rst && w_flush_ifid;
    assign flush_idex = !rst && w_flush_idex;
    assign fwd_a      = rst ? FWD_RF : w_fwd_a;
    assign fwd_b      = rst ? FWD_RF : w_fwd_b;

endmodule
